ntt_radix2_pipe: RTL and testbench

// Fully pipelined radix-2 number-theoretic transform over one RNS residue channel.

---
 rtl/ntt_radix2_pipe.sv | 132 +++++++++++++
 tb/tb_ntt_radix2_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_radix2_pipe.sv
// Fully pipelined radix-2 Cooley-Tukey NTT / inverse NTT over one prime residue channel.
// Input register bit-reverses (and scales by N^-1 for inverse beats), then log2(N) butterfly stages and a holding output register.
module ntt_radix2_pipe #(
  parameter int             W         = 32,
  parameter int             N         = 8,
  parameter logic [W-1:0]   Modulus_Q = 17,
  parameter logic [W-1:0]   OMEGA     = 2,
  parameter logic [W-1:0]   OMEGA_INV = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_valid_in,
  input  logic         iNTT_mode,
  input  logic [W-1:0] Data_in  [0:N-1],
  output logic [W-1:0] Data_out [0:N-1],
  output logic         data_valid_out,
  output logic         mode_out
);

  localparam int S = $clog2(N);

  typedef logic [W-1:0]   word_t;
  typedef logic [2*W-1:0] wide_t;

  localparam wide_t QW = {{W{1'b0}}, Modulus_Q};

  function automatic word_t mul_mod(input word_t a, input word_t b);
    wide_t p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % QW;
    return p[W-1:0];
  endfunction

  function automatic word_t add_mod(input word_t a, input word_t b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Modulus_Q})
      s = s - {1'b0, Modulus_Q};
    return s[W-1:0];
  endfunction

  // Wrap-around in W bits is harmless: the true result always lies in [0,Q).
  function automatic word_t sub_mod(input word_t a, input word_t b);
    return (a >= b) ? (a - b) : (a - b + Modulus_Q);
  endfunction

  function automatic word_t pow_mod(input word_t base, input word_t e);
    word_t r;
    word_t b;
    r = word_t'(1);
    b = mul_mod(base, r);
    for (int i = 0; i < W; i++) begin
      if (e[i])
        r = mul_mod(r, b);
      b = mul_mod(b, b);
    end
    return r;
  endfunction

  function automatic int bit_rev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < S; b++)
      if (v[b])
        r = r | (1 << (S - 1 - b));
    return r;
  endfunction

  // Q is prime, so Fermat gives the inverse of N.
  localparam word_t N_INV = pow_mod(word_t'(N), Modulus_Q - word_t'(2));

  word_t       stage_data [0:S][0:N-1];
  logic [S:0]  stage_valid;
  logic [S:0]  stage_mode;
  word_t       bf [1:S][0:N-1];

  // Stage s combines pairs HALF apart inside blocks of LEN; twiddle exponent scales by N/LEN.
  for (genvar s = 1; s <= S; s++) begin : g_stage
    localparam int HALF = 1 << (s - 1);
    localparam int LEN  = 1 << s;
    for (genvar p = 0; p < N / 2; p++) begin : g_bfly
      localparam int    TOP    = (p / HALF) * LEN + (p % HALF);
      localparam int    BOT    = TOP + HALF;
      localparam word_t TW_FWD = pow_mod(OMEGA, word_t'((p % HALF) * (N / LEN)));
      localparam word_t TW_INV = pow_mod(OMEGA_INV, word_t'((p % HALF) * (N / LEN)));
      word_t prod;
      assign prod         = mul_mod(stage_data[s-1][BOT], stage_mode[s-1] ? TW_INV : TW_FWD);
      assign bf[s][TOP]   = add_mod(stage_data[s-1][TOP], prod);
      assign bf[s][BOT]   = sub_mod(stage_data[s-1][TOP], prod);
    end
  end

  // Data only moves where its valid bit is set, so idle cycles leave every stage untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
      stage_mode  <= '0;
    end else begin
      stage_valid <= {stage_valid[S-1:0], data_valid_in};
      if (data_valid_in) begin
        stage_mode[0] <= iNTT_mode;
        for (int i = 0; i < N; i++)
          stage_data[0][i] <= iNTT_mode ? mul_mod(Data_in[bit_rev(i)], N_INV)
                                        : Data_in[bit_rev(i)];
      end
      for (int s = 1; s <= S; s++) begin
        if (stage_valid[s-1]) begin
          stage_mode[s] <= stage_mode[s-1];
          for (int i = 0; i < N; i++)
            stage_data[s][i] <= bf[s][i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid_out <= 1'b0;
      mode_out       <= 1'b0;
      for (int i = 0; i < N; i++)
        Data_out[i] <= '0;
    end else begin
      data_valid_out <= stage_valid[S];
      if (stage_valid[S]) begin
        mode_out <= stage_mode[S];
        for (int i = 0; i < N; i++)
          Data_out[i] <= stage_data[S][i];
      end
    end
  end

endmodule

// File: tb/tb_ntt_radix2_pipe.sv
// Bench for ntt_radix2_pipe: directed N=4/Q=17 vectors plus randomized N=8 round trips over a 30-bit prime.
module tb_ntt_radix2_pipe;

  localparam longint unsigned Q8 = 64'd998244353;

  function automatic longint unsigned powm(input longint unsigned b, input longint unsigned e,
                                           input longint unsigned q);
    longint unsigned r;
    longint unsigned bb;
    longint unsigned ee;
    r  = 1;
    bb = b % q;
    ee = e;
    while (ee != 0) begin
      if (ee[0])
        r = (r * bb) % q;
      bb = (bb * bb) % q;
      ee = ee >> 1;
    end
    return r;
  endfunction

  // 3 generates the multiplicative group of Q8, so this root has order exactly 8.
  localparam longint unsigned W8  = powm(64'd3, (Q8 - 1) / 8, Q8);
  localparam longint unsigned W8I = powm(W8, 64'd7, Q8);

  typedef longint unsigned vec8_t [0:7];

  typedef struct {
    bit          mode;
    logic [31:0] din  [0:3];
    logic [31:0] dexp [0:3];
  } vec_t;

  typedef struct {
    bit              mode;
    longint unsigned d [0:7];
  } exp8_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        v4_in, m4_in, v4_out, m4_out;
  logic [31:0] d4_in [0:3];
  logic [31:0] d4_out [0:3];
  logic        v8_in, m8_in, v8_out, m8_out;
  logic [31:0] d8_in [0:7];
  logic [31:0] d8_out [0:7];

  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  int    rand_idx = 0;
  exp8_t exp8_q [$];
  exp8_t mon_e;
  vec_t  tbl [4];

  always #5 clk = ~clk;

  ntt_radix2_pipe #(.W(32), .N(4), .Modulus_Q(32'd17), .OMEGA(32'd4), .OMEGA_INV(32'd13)) dut4 (
    .clk(clk), .reset(reset), .data_valid_in(v4_in), .iNTT_mode(m4_in), .Data_in(d4_in),
    .Data_out(d4_out), .data_valid_out(v4_out), .mode_out(m4_out));

  ntt_radix2_pipe #(.W(32), .N(8), .Modulus_Q(32'(Q8)), .OMEGA(32'(W8)), .OMEGA_INV(32'(W8I))) dut8 (
    .clk(clk), .reset(reset), .data_valid_in(v8_in), .iNTT_mode(m8_in), .Data_in(d8_in),
    .Data_out(d8_out), .data_valid_out(v8_out), .mode_out(m8_out));

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Straight O(N^2) transform from the defining sums.
  task automatic model_ntt(input vec8_t x, input bit inv, output vec8_t y);
    longint unsigned w, acc;
    w = inv ? W8I : W8;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int j = 0; j < 8; j++)
        acc = (acc + (x[j] * powm(w, longint'(j * k), Q8)) % Q8) % Q8;
      if (inv)
        acc = (acc * powm(64'd8, Q8 - 2, Q8)) % Q8;
      y[k] = acc;
    end
  endtask

  task automatic apply_stimulus(input bit mode, input logic [31:0] d [0:3]);
    @(negedge clk);
    v4_in = 1'b1;
    m4_in = mode;
    d4_in = d;
    @(negedge clk);
    v4_in = 1'b0;
  endtask

  task automatic wait_valid4(output int cycles);
    cycles = 0;
    while (!v4_out && cycles < 12) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic check_output(input string tag, input bit mode, input logic [31:0] e [0:3]);
    for (int j = 0; j < 4; j++)
      check_val($sformatf("%s_d%0d", tag, j), d4_out[j], e[j]);
    check_val($sformatf("%s_mode", tag), m4_out, mode);
  endtask

  always @(negedge clk) begin
    if (mon_en && v8_out) begin
      if (exp8_q.size() == 0) begin
        check_val("rand_unexpected_pulse", 1, 0);
      end else begin
        mon_e = exp8_q.pop_front();
        for (int j = 0; j < 8; j++)
          check_val($sformatf("rand%0d_d%0d", rand_idx, j), d8_out[j], mon_e.d[j]);
        check_val($sformatf("rand%0d_mode", rand_idx), m8_out, mon_e.mode);
        rand_idx++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int    lat;
    bit    seen;
    vec8_t x, xf;
    exp8_t e;
    logic [31:0] inv_in [0:3];
    logic [31:0] exp_b  [0:3];

    tbl[0].mode = 1'b0; tbl[0].din = '{1, 0, 0, 0};   tbl[0].dexp = '{1, 1, 1, 1};
    tbl[1].mode = 1'b0; tbl[1].din = '{1, 2, 3, 4};   tbl[1].dexp = '{10, 7, 15, 6};
    tbl[2].mode = 1'b1; tbl[2].din = '{10, 7, 15, 6}; tbl[2].dexp = '{1, 2, 3, 4};
    tbl[3].mode = 1'b0; tbl[3].din = '{5, 5, 5, 5};   tbl[3].dexp = '{3, 0, 0, 0};

    reset = 1'b1;
    v4_in = 1'b0; m4_in = 1'b0; d4_in = '{0, 0, 0, 0};
    v8_in = 1'b0; m8_in = 1'b0;
    for (int j = 0; j < 8; j++) d8_in[j] = '0;
    repeat (2) @(negedge clk);
    check_val("reset_valid", v4_out, 0);
    check_val("reset_mode", m4_out, 0);
    for (int j = 0; j < 4; j++)
      check_val($sformatf("reset_d%0d", j), d4_out[j], 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      apply_stimulus(tbl[i].mode, tbl[i].din);
      wait_valid4(lat);
      check_val($sformatf("tbl%0d_latency", i), lat, 3);
      check_output($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].dexp);
      @(negedge clk);
      check_val($sformatf("tbl%0d_pulse_width", i), v4_out, 0);
      check_output($sformatf("tbl%0d_hold", i), tbl[i].mode, tbl[i].dexp);
    end

    // Back-to-back forward then inverse beats, each carrying its own mode.
    inv_in = '{10, 7, 15, 6};
    exp_b  = '{1, 2, 3, 4};
    @(negedge clk);
    v4_in = 1'b1; m4_in = 1'b0; d4_in = '{5, 5, 5, 5};
    @(negedge clk);
    m4_in = 1'b1; d4_in = inv_in;
    @(negedge clk);
    v4_in = 1'b0;
    wait_valid4(lat);
    check_val("b2b_latency", lat, 2);
    check_output("b2b_first", 1'b0, tbl[3].dexp);
    @(negedge clk);
    check_val("b2b_second_valid", v4_out, 1);
    check_output("b2b_second", 1'b1, exp_b);
    @(negedge clk);
    check_val("b2b_pulse_end", v4_out, 0);

    // Reset one cycle after accepting a beat must flush it.
    @(negedge clk);
    v4_in = 1'b1; m4_in = 1'b0; d4_in = '{1, 2, 3, 4};
    @(negedge clk);
    v4_in = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("flush_mode", m4_out, 0);
    for (int j = 0; j < 4; j++)
      check_val($sformatf("flush_d%0d", j), d4_out[j], 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (v4_out) seen = 1'b1;
    end
    check_val("flush_no_pulse", seen, 0);

    // Reset wins over a simultaneous valid input.
    @(negedge clk);
    reset = 1'b1; v4_in = 1'b1; d4_in = '{1, 2, 3, 4};
    @(negedge clk);
    reset = 1'b0; v4_in = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (v4_out) seen = 1'b1;
    end
    check_val("reset_priority_no_pulse", seen, 0);

    // Randomized round trips: forward x checked against the model, then inverse of the model output must give x.
    mon_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      for (int j = 0; j < 8; j++)
        x[j] = longint'($urandom) % Q8;
      model_ntt(x, 1'b0, xf);
      @(negedge clk);
      v8_in = 1'b1; m8_in = 1'b0;
      for (int j = 0; j < 8; j++) d8_in[j] = 32'(x[j]);
      e.mode = 1'b0; e.d = xf;
      exp8_q.push_back(e);
      @(negedge clk);
      m8_in = 1'b1;
      for (int j = 0; j < 8; j++) d8_in[j] = 32'(xf[j]);
      e.mode = 1'b1; e.d = x;
      exp8_q.push_back(e);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        v8_in = 1'b0;
      end
    end
    @(negedge clk);
    v8_in = 1'b0;
    repeat (10) @(negedge clk);
    check_val("rand_all_beats_returned", exp8_q.size(), 0);
    check_val("rand_beat_count", rand_idx, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
